// File: rtl/i2s_pkg.sv
// ============================================================================
// Module   : i2s_pkg
// Desc     : Shared types and constants for the I2S transmit controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int c_DATA_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH_L = 3'd1,
    S_FETCH_R = 3'd2,
    S_PUSH_L  = 3'd3,
    S_PUSH_R  = 3'd4,
    S_WAIT    = 3'd5
  } i2s_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] i_val);
    return (i_val == 16'hFFFF) ? i_val : i_val + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module   : i2s_clk_gen
// Desc     : Bit clock / word select generator with frame-boundary strobe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
  parameter int SCK_DIV    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  output logic                          o_sck,
  output logic                          o_ws,
  output logic [$clog2(DATA_WIDTH)-1:0] o_bit_cnt,
  output logic                          o_frame
);

  localparam int c_DIV_W = $clog2(SCK_DIV);
  localparam int c_BIT_W = $clog2(DATA_WIDTH);

  logic [c_DIV_W-1:0] r_div;
  logic [c_BIT_W-1:0] r_bit;
  logic               r_ws;
  logic               w_fall;
  logic               w_bit_last;

  // w_fall marks the cycle whose closing edge drops sck (divider wraps).
  assign w_fall     = i_enable && (r_div == c_DIV_W'(SCK_DIV - 1));
  assign w_bit_last = (r_bit == c_BIT_W'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_bit <= '0;
      r_ws  <= 1'b0;
    end else if (!i_enable) begin
      r_div <= '0;
      r_bit <= '0;
      r_ws  <= 1'b0;
    end else begin
      r_div <= w_fall ? '0 : r_div + c_DIV_W'(1);
      if (w_fall) begin
        r_bit <= w_bit_last ? '0 : r_bit + c_BIT_W'(1);
        if (w_bit_last) begin
          r_ws <= ~r_ws;
        end
      end
    end
  end

  assign o_sck     = (r_div >= c_DIV_W'(SCK_DIV / 2));
  assign o_ws      = r_ws;
  assign o_bit_cnt = r_bit;
  assign o_frame   = w_fall && w_bit_last && r_ws;

endmodule

`default_nettype wire

// File: rtl/i2s_tx_controller.sv
// ============================================================================
// Module   : i2s_tx_controller
// Desc     : Selects one of two AXIS sample sources per I2S frame and
//            forwards a left/right pair per frame to the transmitter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2s_tx_controller
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
  parameter int SCK_DIV    = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                  S0_AXIS_TVALID,
  input  logic                  S0_AXIS_TLAST,
  output logic                  S0_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                  S1_AXIS_TVALID,
  input  logic                  S1_AXIS_TLAST,
  output logic                  S1_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  input  logic                  sel,
  input  logic                  mute,
  input  logic                  enable,
  output logic                  sck,
  output logic                  ws,
  output logic                  active_src,
  output logic [15:0]           underrun_count
);

  localparam int c_BIT_W = $clog2(DATA_WIDTH);

  logic [c_BIT_W-1:0]    w_bit;
  logic                  w_frame;
  logic                  w_ws;

  i2s_state_e            r_state;
  i2s_state_e            w_state_nxt;
  logic                  r_active_src;
  logic [DATA_WIDTH-1:0] r_left;
  logic [DATA_WIDTH-1:0] r_right;
  logic                  r_late;
  logic [15:0]           r_underrun_cnt;

  logic [DATA_WIDTH-1:0] w_src_data;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic                  w_fetch;
  logic                  w_push;
  logic                  w_src_hs;
  logic                  w_fetch_timeout;
  logic                  w_store_left;
  logic                  w_store_right;
  logic                  w_zero_fill;
  logic                  w_underrun;

  i2s_clk_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .SCK_DIV    (SCK_DIV)
  ) u_clk_gen (
    .clk       (ACLK),
    .rst       (ARESET),
    .i_enable  (enable),
    .o_sck     (sck),
    .o_ws      (w_ws),
    .o_bit_cnt (w_bit),
    .o_frame   (w_frame)
  );

  assign w_src_data  = r_active_src ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign w_src_valid = r_active_src ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign w_src_last  = r_active_src ? S1_AXIS_TLAST  : S0_AXIS_TLAST;

  assign w_fetch  = (r_state == S_FETCH_L) || (r_state == S_FETCH_R);
  assign w_push   = (r_state == S_PUSH_L)  || (r_state == S_PUSH_R);
  assign w_src_hs = w_fetch && w_src_valid;
  // Half-way through the left slot is the last moment a pair can still be sent.
  assign w_fetch_timeout = w_fetch && !w_ws && (w_bit == c_BIT_W'(DATA_WIDTH / 2));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_store_left  = 1'b0;
    w_store_right = 1'b0;
    w_zero_fill   = 1'b0;
    w_underrun    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_frame) w_state_nxt = S_FETCH_L;
      end
      S_FETCH_L: begin
        if (w_fetch_timeout) begin
          w_zero_fill = 1'b1;
          w_underrun  = 1'b1;
          w_state_nxt = S_PUSH_L;
        end else if (w_src_hs && !w_src_last) begin
          w_store_left = 1'b1;
          w_state_nxt  = S_FETCH_R;
        end
      end
      S_FETCH_R: begin
        if (w_fetch_timeout) begin
          w_zero_fill = 1'b1;
          w_underrun  = 1'b1;
          w_state_nxt = S_PUSH_L;
        end else if (w_src_hs && w_src_last) begin
          w_store_right = 1'b1;
          w_state_nxt   = S_PUSH_L;
        end else if (w_src_hs) begin
          w_store_left = 1'b1;
        end
      end
      S_PUSH_L: begin
        w_underrun = w_frame;
        if (M_AXIS_TREADY) w_state_nxt = S_PUSH_R;
      end
      S_PUSH_R: begin
        w_underrun = w_frame;
        if (M_AXIS_TREADY) w_state_nxt = (r_late || w_frame) ? S_FETCH_L : S_WAIT;
      end
      S_WAIT: begin
        if (w_frame) w_state_nxt = S_FETCH_L;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (!enable) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_active_src   <= 1'b0;
      r_left         <= '0;
      r_right        <= '0;
      r_late         <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      if (w_frame) r_active_src <= sel;
      // Mute is applied once, as the pair is committed for output.
      if (w_zero_fill) begin
        r_left  <= '0;
        r_right <= '0;
      end else if (w_store_right) begin
        r_right <= mute ? '0 : w_src_data;
        r_left  <= mute ? '0 : r_left;
      end else if (w_store_left) begin
        r_left <= w_src_data;
      end
      if (!enable || ((r_state == S_PUSH_R) && M_AXIS_TREADY)) begin
        r_late <= 1'b0;
      end else if (w_push && w_frame) begin
        r_late <= 1'b1;
      end
      if (w_underrun) r_underrun_cnt <= sat_inc16(r_underrun_cnt);
    end
  end

  assign S0_AXIS_TREADY = w_fetch && !r_active_src;
  assign S1_AXIS_TREADY = w_fetch &&  r_active_src;
  assign M_AXIS_TVALID  = w_push;
  assign M_AXIS_TLAST   = (r_state == S_PUSH_R);
  assign M_AXIS_TDATA   = (r_state == S_PUSH_L) ? r_left  :
                          (r_state == S_PUSH_R) ? r_right : '0;
  assign ws             = w_ws;
  assign active_src     = r_active_src;
  assign underrun_count = r_underrun_cnt;

endmodule

`default_nettype wire
